cordic_ln_arbiter: RTL
======================

# cordic_ln_arbiter

Round-robin scheduler that shares one fixed-latency CORDIC natural-log pipeline among `NREQ` requesters.
- Accepts at most one Q16.16 operand per cycle over valid/ready.
- Issues it to the ln core and carries the requester ID alongside the core's latency in a tag delay line.
- Returns each result tagged with the originating ID.
- Sits between the per-channel feature extractors and the single shared ln core.

## Interface
- `NREQ`, 4: number of requesters, 2..8.
- `PIPELINE`, 16: core pipeline depth. Core latency is `LAT = PIPELINE+2` cycles, from `core_valid` to `core_result_valid`.
- `IDW`, `$clog2(NREQ)`: width of the result ID.
- `clk` in 1: the single clock.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in NREQ: per-requester operand valid.
- `req_data` in NREQ*32: signed Q16.16 operands; requester i uses bits [32i+31:32i].
- `req_ready` out NREQ: one-hot grant, combinational.
- `core_data` out 32: registered operand to the core.
- `core_valid` out 1: registered issue strobe to the core.
- `core_result` in 32: core ln output, Q16.16.
- `core_result_valid` in 1: core output strobe.
- `res_valid` out 1: one-cycle result pulse.
- `res_id` out IDW: requester ID of the result.
- `res_data` out 32: signed Q16.16 ln result.
- `res_range_err` out 1: result belongs to an out-of-range operand.
- `inflight` out 6: number of accepted operands not yet returned.
- `idle` out 1: high when `inflight==0`.
- `sync_err` out 1: sticky tag/core misalignment flag.

## Operation
- **Arbitration**
  - Round-robin pointer `last` holds the most recently granted ID.
  - The search starts at `last+1` and wraps modulo `NREQ`.
  - `req_ready[i]` is asserted only for the first i found with `req_valid[i]` set.
  - A transfer occurs on `req_valid[i] & req_ready[i]`; `last` updates to i on that edge.
  - When no requester is valid, `last` holds.
- **Issue**
  - On a transfer, `core_data <= req_data[i]` and `core_valid <= 1`.
  - Otherwise `core_valid <= 0` and `core_data` holds.
- **Tag line**
  - A shift register of depth `LAT+1` carries {valid, id, range_err}.
  - It is written on the transfer edge and advances every cycle. It never stalls, because the core cannot stall.
- **Return**
  - When the tag-line tail is valid, the block registers `res_valid=1`, `res_id=tag id`, `res_data=core_result` (or 0 if range_err), `res_range_err=tag range_err`.
- **Consistency check**
  - A mismatch between tail valid (excluding range_err entries) and `core_result_valid` sets `sync_err`.
  - `sync_err` clears only on reset.
- **inflight counter**
  - Increments on transfer and decrements on `res_valid`.
  - Both in the same cycle: the count holds.
  - The counter saturates at `LAT+2`, which cannot be exceeded in legal operation.
- **Reset** (including mid-operation)
  - The tag line is cleared, so in-flight results are dropped; late core outputs without a tag set `sync_err` only if they arrive after reset deasserts.
  - `last` resets to `NREQ-1`, so requester 0 wins first.

## Timing
- Reset values: `req_ready` follows arbitration (0 while `rst`), `core_valid=0`, `core_data=0`, `res_valid=0`, `res_id=0`, `res_data=0`, `res_range_err=0`, `inflight=0`, `idle=1`, `sync_err=0`.
- Accept edge t: `core_valid` is high in cycle t+1; `res_valid` is high in cycle t+LAT+2 = t+`PIPELINE`+4.
- Throughput is one operand per cycle sustained. Back-to-back grants to the same requester are allowed only when it is the sole valid requester.
- Results return strictly in acceptance order; there are no ID collisions.

## Configuration
- `CORDIC_ARB_RANGE_CHECK_EN` defined:
  - An operand outside [6554, 627835] (0.1..9.58 in Q16.16) is accepted, but not issued: `core_valid` stays 0 that cycle.
  - It is tagged range_err and returns at the normal latency with `res_data=0`, `res_range_err=1`.
- `CORDIC_ARB_RANGE_CHECK_EN` undefined:
  - Every operand is issued and `res_range_err` is tied 0.

## Structure
- Shared package `cordic_pkg` holds:
  - Q16.16 constants `LN_MIN=32'sd6554`, `LN_MAX=32'sd627835`, `Q_ONE=32'sd65536`.
  - The tag struct typedef {valid, id, range_err}.
  - The `LAT` function of `PIPELINE`.
- One sub-module, `cordic_tag_delay`: a parameterised-depth shift register with synchronous clear.
- The round-robin pick stays inline.

## Test plan
- Single requester 0 sends 65536 → `res_valid` at accept+20 with `res_id=0` and `res_data` within ±16 of 0; `idle` returns to 1.
- All 4 requesters valid continuously for 8 cycles → grants 0,1,2,3,0,1,2,3; results return in that ID order, one per cycle.
- Requester 2 sends 178145 (e) while requester 1 sends 131072 (2) in the next cycle → results ≈65536 (ID 2) then ≈45426 (ID 1), each within ±16.
- With the macro defined, an operand of 1000 → no `core_valid`; `res_range_err=1` and `res_data=0` at accept+20. Without the macro → issued, with `res_range_err=0`.
- `rst` asserted for 1 cycle with 10 operations in flight → no `res_valid` afterwards, `inflight=0`, and `sync_err` set if the core keeps emitting.
- Core model delays `core_result_valid` by one extra cycle → `sync_err` becomes 1 and stays 1 until `rst`.

Source files
------------

// File: rtl/cordic_pkg.sv
// Shared constants, tag payload and latency helper for the CORDIC ln arbiter.
package cordic_pkg;

  localparam logic signed [31:0] LN_MIN = 32'sd6554;
  localparam logic signed [31:0] LN_MAX = 32'sd627835;
  localparam logic signed [31:0] Q_ONE  = 32'sd65536;

  // Sized for the largest supported requester count (8).
  localparam int unsigned TAG_IDW = 3;

  typedef struct packed {
    logic               valid;
    logic [TAG_IDW-1:0] id;
    logic               range_err;
  } tag_t;

  function automatic int unsigned lat(input int unsigned pipeline);
    return pipeline + 32'd2;
  endfunction

endpackage

// File: rtl/cordic_tag_delay.sv
// Fixed-depth tag shift register with synchronous clear; never stalls.
module cordic_tag_delay
  import cordic_pkg::*;
#(
  parameter int unsigned DEPTH = 19
) (
  input  logic clk,
  input  logic clr_i,
  input  tag_t tag_i,
  output tag_t tail_o
);

  tag_t line_q [DEPTH];
  tag_t line_d [DEPTH];

  always_comb begin
    line_d[0] = tag_i;
    for (int unsigned k = 1; k < DEPTH; k++) begin
      line_d[k] = line_q[k-1];
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned k = 0; k < DEPTH; k++) begin
      line_q[k] <= clr_i ? '0 : line_d[k];
    end
  end

  assign tail_o = line_q[DEPTH-1];

endmodule

// File: rtl/cordic_ln_arbiter.sv
// Round-robin front end sharing one fixed-latency CORDIC ln core; results return tagged with requester ID.
// Optional operand range screening enabled by defining CORDIC_ARB_RANGE_CHECK_EN.
module cordic_ln_arbiter
  import cordic_pkg::*;
#(
  parameter int unsigned NREQ     = 4,
  parameter int unsigned PIPELINE = 16,
  parameter int unsigned IDW      = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*32-1:0]   req_data,
  output logic [NREQ-1:0]      req_ready,
  output logic [31:0]          core_data,
  output logic                 core_valid,
  input  logic [31:0]          core_result,
  input  logic                 core_result_valid,
  output logic                 res_valid,
  output logic [IDW-1:0]       res_id,
  output logic [31:0]          res_data,
  output logic                 res_range_err,
  output logic [5:0]           inflight,
  output logic                 idle,
  output logic                 sync_err
);

  localparam int unsigned LAT   = lat(PIPELINE);
  localparam int unsigned DEPTH = LAT + 1;
  localparam int unsigned CNTW  = 6;
  localparam logic [CNTW-1:0] INF_MAX = CNTW'(LAT + 2);

  logic [IDW-1:0]  last_q, last_d;
  logic [IDW-1:0]  cand, grant_id;
  logic            grant_any;
  logic [31:0]     grant_data;
  logic            range_err;
  logic            core_valid_q, core_valid_d;
  logic [31:0]     core_data_q, core_data_d;
  tag_t            tag_in, tag_tail;
  logic            tag_id_unused;
  logic            res_valid_q, res_valid_d;
  logic [IDW-1:0]  res_id_q, res_id_d;
  logic [31:0]     res_data_q, res_data_d;
  logic            res_range_err_q, res_range_err_d;
  logic [CNTW-1:0] inflight_q, inflight_d;
  logic            idle_q, idle_d;
  logic            sync_err_q, sync_err_d;

  // Round-robin search starting one past the last grant.
  always_comb begin
    req_ready = '0;
    grant_any = 1'b0;
    grant_id  = '0;
    cand      = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      cand = IDW'((32'(last_q) + k) % NREQ);
      if (!grant_any && !rst && req_valid[cand]) begin
        grant_any = 1'b1;
        grant_id  = cand;
      end
    end
    req_ready[grant_id] = grant_any;
  end

  assign grant_data = req_data[{grant_id, 5'b0} +: 32];

`ifdef CORDIC_ARB_RANGE_CHECK_EN
  assign range_err = ($signed(grant_data) < LN_MIN) || ($signed(grant_data) > LN_MAX);
`else
  assign range_err = 1'b0;
`endif

  always_comb begin
    last_d       = grant_any ? grant_id : last_q;
    core_valid_d = grant_any & ~range_err;
    core_data_d  = core_valid_d ? grant_data : core_data_q;
    tag_in       = '0;
    if (grant_any) begin
      tag_in.valid     = 1'b1;
      tag_in.id        = TAG_IDW'(grant_id);
      tag_in.range_err = range_err;
    end
  end

  cordic_tag_delay #(
    .DEPTH (DEPTH)
  ) u_tag_delay (
    .clk    (clk),
    .clr_i  (rst),
    .tag_i  (tag_in),
    .tail_o (tag_tail)
  );

  assign tag_id_unused = ^tag_tail.id;

  // Result capture, alignment check and occupancy tracking.
  always_comb begin
    res_valid_d     = tag_tail.valid;
    res_id_d        = res_id_q;
    res_data_d      = res_data_q;
    res_range_err_d = res_range_err_q;
    if (tag_tail.valid) begin
      res_id_d        = IDW'(tag_tail.id);
      res_data_d      = tag_tail.range_err ? '0 : core_result;
      res_range_err_d = tag_tail.range_err;
    end

    sync_err_d = sync_err_q | ((tag_tail.valid & ~tag_tail.range_err) ^ core_result_valid);

    inflight_d = inflight_q;
    if (grant_any && !res_valid_q && inflight_q != INF_MAX) begin
      inflight_d = inflight_q + CNTW'(1);
    end else if (!grant_any && res_valid_q && inflight_q != '0) begin
      inflight_d = inflight_q - CNTW'(1);
    end
    idle_d = (inflight_d == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_q          <= IDW'(NREQ - 1);
      core_valid_q    <= 1'b0;
      core_data_q     <= '0;
      res_valid_q     <= 1'b0;
      res_id_q        <= '0;
      res_data_q      <= '0;
      res_range_err_q <= 1'b0;
      inflight_q      <= '0;
      idle_q          <= 1'b1;
      sync_err_q      <= 1'b0;
    end else begin
      last_q          <= last_d;
      core_valid_q    <= core_valid_d;
      core_data_q     <= core_data_d;
      res_valid_q     <= res_valid_d;
      res_id_q        <= res_id_d;
      res_data_q      <= res_data_d;
      res_range_err_q <= res_range_err_d;
      inflight_q      <= inflight_d;
      idle_q          <= idle_d;
      sync_err_q      <= sync_err_d;
    end
  end

  assign core_valid    = core_valid_q;
  assign core_data     = core_data_q;
  assign res_valid     = res_valid_q;
  assign res_id        = res_id_q;
  assign res_data      = res_data_q;
  assign res_range_err = res_range_err_q;
  assign inflight      = inflight_q;
  assign idle          = idle_q;
  assign sync_err      = sync_err_q;

endmodule
